// File: rtl/spi_tx_feeder_pkg.sv
// rtl/spi_tx_feeder_pkg.sv - shared widths, defaults and state encoding for the SPI transmit path
package spi_tx_feeder_pkg;

    localparam int SPI_SDEPTH = 8;
    localparam int SPI_CWIDTH = 3;
    localparam int DEF_FDEPTH = 4;
    localparam int DEF_AWIDTH = 2;

    localparam logic [SPI_SDEPTH-1:0] IDLE_BYTE = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        LOAD  = 2'b10
    } feeder_state_e;

endpackage

// File: rtl/spi_tx_fifo.sv
// rtl/spi_tx_fifo.sv - circular byte buffer with level counter and full/empty decode
module spi_tx_fifo #(
    parameter int SDEPTH = 8,
    parameter int FDEPTH = 4,
    parameter int AWIDTH = 2
) (
    input  logic              SPI_Clk,
    input  logic              SPI_ResetN,
    input  logic              Push_i,
    input  logic [SDEPTH-1:0] Push_Data_i,
    input  logic              Pop_i,
    output logic [SDEPTH-1:0] Head_o,
    output logic [AWIDTH:0]   Level_o,
    output logic              FullN_o,
    output logic              EmptyN_o,
    output logic              Drop_o
);

    localparam logic [AWIDTH:0] FULL_LEVEL = (AWIDTH+1)'(FDEPTH);

    logic [SDEPTH-1:0] mem_q [FDEPTH];
    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   level_q, level_d;
    logic              full;
    logic              push_ok;

    assign full     = (level_q == FULL_LEVEL);
    assign FullN_o  = !full;
    assign EmptyN_o = (level_q != '0);
    assign Level_o  = level_q;
    assign Head_o   = mem_q[rd_ptr_q];

    // A pop frees the slot the same cycle, so a write into a full buffer still lands.
    assign push_ok = Push_i && (!full || Pop_i);
    assign Drop_o  = Push_i && full && !Pop_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (Pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, Pop_i})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge SPI_Clk or negedge SPI_ResetN) begin
        if (!SPI_ResetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge SPI_Clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= Push_Data_i;
        end
    end

endmodule

// File: rtl/spi_tx_feeder.sv
// rtl/spi_tx_feeder.sv - feeds buffered bytes to the SPI shifter on each almost-empty slot
module spi_tx_feeder
    import spi_tx_feeder_pkg::*;
#(
    parameter int SDEPTH = SPI_SDEPTH,
    parameter int FDEPTH = DEF_FDEPTH,
    parameter int AWIDTH = DEF_AWIDTH
) (
    input  logic              SPI_Clk,
    input  logic              SPI_ResetN,
    input  logic              Wr_En,
    input  logic [SDEPTH-1:0] Wr_Data,
    input  logic              Frame_Active,
    input  logic              SPI_AlmostEmptyN,
    output logic              SPI_Data_RdyN,
    output logic [SDEPTH-1:0] SPI_Data_Out,
    output logic              Fifo_FullN,
    output logic              Fifo_EmptyN,
    output logic [AWIDTH:0]   Fifo_Level,
    output logic              Underrun,
    output logic              Overflow,
    input  logic              Flag_Clr
);

    feeder_state_e     state_q, state_d;
    logic              rdyn_q, rdyn_d;
    logic [SDEPTH-1:0] dout_q, dout_d;
    logic              underrun_q, underrun_d;
    logic              overflow_q, overflow_d;
    logic              slot;
    logic              pop;
    logic              underrun_set;
    logic              drop;
    logic [SDEPTH-1:0] head;

    assign slot = !SPI_AlmostEmptyN;

    spi_tx_fifo #(
        .SDEPTH (SDEPTH),
        .FDEPTH (FDEPTH),
        .AWIDTH (AWIDTH)
    ) u_fifo (
        .SPI_Clk     (SPI_Clk),
        .SPI_ResetN  (SPI_ResetN),
        .Push_i      (Wr_En),
        .Push_Data_i (Wr_Data),
        .Pop_i       (pop),
        .Head_o      (head),
        .Level_o     (Fifo_Level),
        .FullN_o     (Fifo_FullN),
        .EmptyN_o    (Fifo_EmptyN),
        .Drop_o      (drop)
    );

    // Pop eligibility looks at the registered level, so a same-cycle write waits a slot.
    always_comb begin
        state_d      = state_q;
        rdyn_d       = 1'b1;
        dout_d       = dout_q;
        pop          = 1'b0;
        underrun_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (Frame_Active) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (slot) begin
                    if (Fifo_EmptyN) begin
                        pop     = 1'b1;
                        dout_d  = head;
                        rdyn_d  = 1'b0;
                        state_d = LOAD;
                    end else begin
                        underrun_set = 1'b1;
                    end
                end else if (!Frame_Active) begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d = Frame_Active ? ARMED : IDLE;
            end
            default: state_d = IDLE;
        endcase

        underrun_d = underrun_set || (underrun_q && !Flag_Clr);
        overflow_d = drop || (overflow_q && !Flag_Clr);
    end

    always_ff @(posedge SPI_Clk or negedge SPI_ResetN) begin
        if (!SPI_ResetN) begin
            state_q    <= IDLE;
            rdyn_q     <= 1'b1;
            dout_q     <= '1;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdyn_q     <= rdyn_d;
            dout_q     <= dout_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    assign SPI_Data_RdyN = rdyn_q;
    assign SPI_Data_Out  = dout_q;
    assign Underrun      = underrun_q;
    assign Overflow      = overflow_q;

endmodule
